// File: rtl/nes_cart_pkg.sv
// Shared MMC1 cart definitions: register selects, serial protocol constants and
// the writer FSM state type.
package nes_cart_pkg;

    typedef enum logic [1:0] {
        CTRL = 2'd0,
        CHR0 = 2'd1,
        CHR1 = 2'd2,
        PRG  = 2'd3
    } mmc1_reg_t;

    localparam logic [7:0]  MMC1_RESET_DATA = 8'h80;
    localparam int unsigned MMC1_NBITS      = 5;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WRITE,
        WR_GAP,
        WR_DONE
    } mmc1_wr_state_t;

    // Register select lands on A14..A13; the low address bits are don't-care to MMC1.
    function automatic logic [14:0] mmc1_reg_addr(input mmc1_reg_t r);
        return {r, 13'h0};
    endfunction

    function automatic logic [7:0] mmc1_bit_data(input logic [4:0] d, input logic [2:0] k);
        logic [4:0] s;
        s = d >> k;
        return {7'b0, s[0]};
    endfunction

endpackage

// File: rtl/mmc1_serial_writer.sv
// MMC1 serial-port transmitter: replays the 6502 write sequence (optional reset
// write, then five LSB-first bit writes) onto the cart CPU-side bus.
module mmc1_serial_writer #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk_cpu,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_reg,
    input  logic [4:0]  req_data,
    input  logic        req_reset,
    output logic        done,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_rw,
    output logic        romsel,
    output logic        m2
);
    import nes_cart_pkg::*;

    // MMC1 drops consecutive-cycle writes, so at least one idle cycle is mandatory.
    generate
        if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
            $error("mmc1_serial_writer: GAP_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    mmc1_wr_state_t state_q, state_d;
    logic [3:0]     gap_q, gap_d;
    logic [2:0]     bits_q, bits_d;
    logic           rstw_q, rstw_d;
    mmc1_reg_t      reg_q;
    logic [4:0]     data_q;
    logic [14:0]    addr_hold_q;
    logic [7:0]     data_hold_q;
    logic           accept;

    assign accept = (state_q == WR_IDLE) && req_valid;

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            state_q     <= WR_IDLE;
            gap_q       <= '0;
            bits_q      <= '0;
            rstw_q      <= 1'b0;
            reg_q       <= CTRL;
            data_q      <= '0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            bits_q      <= bits_d;
            rstw_q      <= rstw_d;
            addr_hold_q <= cpu_addr;
            data_hold_q <= cpu_data_o;
            if (accept) begin
                reg_q  <= mmc1_reg_t'(req_reg);
                data_q <= req_data;
            end
        end
    end

    // Address/data pins keep showing the previous write outside WR cycles.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        bits_d     = bits_q;
        rstw_d     = rstw_q;
        req_ready  = 1'b0;
        done       = 1'b0;
        cpu_rw     = 1'b1;
        romsel     = 1'b1;
        m2         = 1'b0;
        cpu_addr   = addr_hold_q;
        cpu_data_o = data_hold_q;

        case (state_q)
            WR_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = WR_WRITE;
                    rstw_d  = req_reset;
                    bits_d  = '0;
                end
            end
            WR_WRITE: begin
                cpu_rw   = 1'b0;
                romsel   = 1'b0;
                m2       = 1'b1;
                cpu_addr = mmc1_reg_addr(reg_q);
                if (rstw_q) begin
                    cpu_data_o = MMC1_RESET_DATA;
                    rstw_d     = 1'b0;
                end else begin
                    cpu_data_o = mmc1_bit_data(data_q, bits_q);
                    bits_d     = bits_q + 3'd1;
                end
                gap_d   = GAP_LOAD;
                state_d = WR_GAP;
            end
            WR_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = (bits_q < 3'(MMC1_NBITS)) ? WR_WRITE : WR_DONE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            WR_DONE: begin
                done    = 1'b1;
                state_d = WR_IDLE;
            end
            default: state_d = WR_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Scoreboard bench: a GAP=2 and a GAP=1 writer, each feeding a behavioural MMC1
// shift-register receiver that rebuilds the cart registers.
module tb_mmc1_serial_writer;
    import nes_cart_pkg::*;

    typedef struct {
        int          cyc;
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        int         cyc;
        int         r;
        logic [4:0] val;
    } dn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        valid0 = 1'b0, ready0, reset0 = 1'b0, done0, rw0, romsel0, m2_0;
    logic [1:0]  reg0 = '0;
    logic [4:0]  data0 = '0;
    logic [14:0] addr0;
    logic [7:0]  dout0;

    logic        valid1 = 1'b0, ready1, reset1 = 1'b0, done1, rw1, romsel1, m2_1;
    logic [1:0]  reg1 = '0;
    logic [4:0]  data1 = '0;
    logic [14:0] addr1;
    logic [7:0]  dout1;

    mmc1_serial_writer #(.GAP_CYCLES(2)) u_gap2 (
        .clk_cpu(clk), .rst(rst), .req_valid(valid0), .req_ready(ready0),
        .req_reg(reg0), .req_data(data0), .req_reset(reset0), .done(done0),
        .cpu_addr(addr0), .cpu_data_o(dout0), .cpu_rw(rw0), .romsel(romsel0), .m2(m2_0)
    );

    mmc1_serial_writer #(.GAP_CYCLES(1)) u_gap1 (
        .clk_cpu(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1),
        .req_reg(reg1), .req_data(data1), .req_reset(reset1), .done(done1),
        .cpu_addr(addr1), .cpu_data_o(dout1), .cpu_rw(rw1), .romsel(romsel1), .m2(m2_1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t wq0[$], wq1[$];
    dn_t dq0[$], dq1[$];

    logic [4:0] sr   [2];
    int         cnt  [2];
    logic [4:0] cart [2][4];
    logic       prev_m2 [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_wr(input int idx, input logic [14:0] a, input logic [7:0] d);
        if (d[7]) begin
            sr[idx]  = '0;
            cnt[idx] = 0;
        end else begin
            sr[idx] = {d[0], sr[idx][4:1]};
            cnt[idx]++;
            if (cnt[idx] == 5) begin
                cart[idx][a[14:13]] = sr[idx];
                cnt[idx] = 0;
            end
        end
    endtask

    task automatic push_seq(input int idx, input int acc, input int gap,
                            input logic [1:0] r, input logic [4:0] d, input logic rs);
        int  n = 0;
        wr_t w;
        dn_t e;
        if (rs) begin
            w.cyc = acc + 1; w.addr = {r, 13'h0}; w.data = 8'h80;
            if (idx == 0) wq0.push_back(w); else wq1.push_back(w);
            n = 1;
        end
        for (int k = 0; k < 5; k++) begin
            w.cyc  = acc + 1 + (n + k) * (1 + gap);
            w.addr = {r, 13'h0};
            w.data = {7'b0, d[k]};
            if (idx == 0) wq0.push_back(w); else wq1.push_back(w);
        end
        e.cyc = acc + 1 + (n + 5) * (1 + gap);
        e.r   = int'(r);
        e.val = d;
        if (idx == 0) dq0.push_back(e); else dq1.push_back(e);
    endtask

    task automatic mon_step(input int idx, input logic m, input logic rw, input logic rs_n,
                            input logic [14:0] a, input logic [7:0] d,
                            input logic dn, input logic rdy);
        wr_t w;
        dn_t e;
        bit  have;
        chk($sformatf("bus_pins%0d", idx), {30'b0, rw, rs_n}, m ? 32'd0 : 32'd3);
        chk($sformatf("m2_consecutive%0d", idx), {31'b0, m & prev_m2[idx]}, 32'd0);
        prev_m2[idx] = m;
        if (m) begin
            have = (idx == 0) ? (wq0.size() > 0) : (wq1.size() > 0);
            if (!have) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_write%0d: got addr %0h data %0h expected none (cycle %0d)", idx, a, d, cyc);
            end else begin
                w = (idx == 0) ? wq0.pop_front() : wq1.pop_front();
                chk($sformatf("write_cycle%0d", idx), cyc, w.cyc);
                chk($sformatf("write_addr%0d", idx), {17'b0, a}, {17'b0, w.addr});
                chk($sformatf("write_data%0d", idx), {24'b0, d}, {24'b0, w.data});
            end
            model_wr(idx, a, d);
        end
        if (dn) begin
            chk($sformatf("ready_in_done%0d", idx), {31'b0, rdy}, 32'd0);
            have = (idx == 0) ? (dq0.size() > 0) : (dq1.size() > 0);
            if (!have) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_done%0d: got done expected none (cycle %0d)", idx, cyc);
            end else begin
                e = (idx == 0) ? dq0.pop_front() : dq1.pop_front();
                chk($sformatf("done_cycle%0d", idx), cyc, e.cyc);
                chk($sformatf("cart_reg%0d_%0d", idx, e.r), {27'b0, cart[idx][e.r]}, {27'b0, e.val});
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, m2_0, rw0, romsel0, addr0, dout0, done0, ready0);
            mon_step(1, m2_1, rw1, romsel1, addr1, dout1, done1, ready1);
        end
    end

    // Inputs are scrambled after acceptance so only the latched copies may reach the bus.
    task automatic issue(input int idx, input logic [1:0] r, input logic [4:0] d,
                         input logic rs, input bit hold, input int exp_acc, output int acc);
        int   t = 0;
        logic rdy;
        do begin
            @(negedge clk);
            t++;
            rdy = (idx == 0) ? ready0 : ready1;
        end while (!rdy && t < 200);
        if (!rdy) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout%0d: got ready 0 expected 1 within 200 cycles", idx);
            acc = -1;
        end else begin
            acc = cyc;
            if (exp_acc >= 0) chk($sformatf("accept_cycle%0d", idx), acc, exp_acc);
            if (idx == 0) begin
                reg0 = r; data0 = d; reset0 = rs; valid0 = 1'b1;
            end else begin
                reg1 = r; data1 = d; reset1 = rs; valid1 = 1'b1;
            end
            push_seq(idx, acc, (idx == 0) ? 2 : 1, r, d, rs);
            @(negedge clk);
            if (idx == 0) begin
                reg0 = ~r; data0 = ~d; reset0 = ~rs; valid0 = hold;
            end else begin
                reg1 = ~r; data1 = ~d; reset1 = ~rs; valid1 = hold;
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((wq0.size() + wq1.size() + dq0.size() + dq1.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if ((wq0.size() + wq1.size() + dq0.size() + dq1.size()) != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0",
                     wq0.size() + wq1.size() + dq0.size() + dq1.size());
            wq0.delete(); wq1.delete(); dq0.delete(); dq1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_ready"},  {31'b0, ready0},  32'd1);
        chk({tag, "_done"},   {31'b0, done0},   32'd0);
        chk({tag, "_addr"},   {17'b0, addr0},   32'd0);
        chk({tag, "_data"},   {24'b0, dout0},   32'd0);
        chk({tag, "_rw"},     {31'b0, rw0},     32'd1);
        chk({tag, "_romsel"}, {31'b0, romsel0}, 32'd1);
        chk({tag, "_m2"},     {31'b0, m2_0},    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, acc_a;
        for (int i = 0; i < 2; i++) begin
            sr[i] = '0; cnt[i] = 0; prev_m2[i] = 1'b0;
            for (int j = 0; j < 4; j++) cart[i][j] = '0;
        end

        // A request presented in the final reset cycle must be dropped.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        valid0 = 1'b1; reg0 = 2'd2; data0 = 5'h1F; reset0 = 1'b0;
        @(negedge clk);
        rst = 1'b0; valid0 = 1'b0;
        chk_reset0("reset");
        chk("reset_ready1", {31'b0, ready1}, 32'd1);
        mon_en = 1'b1;

        // PRG = 5'b10110, no reset write: writes at +1,4,7,10,13, done at +16.
        issue(0, 2'd3, 5'b10110, 1'b0, 1'b0, -1, acc);
        drain();

        // Control = 5'h0C preceded by the $80 reset write: done at +19.
        issue(0, 2'd0, 5'h0C, 1'b1, 1'b0, -1, acc);
        drain();

        // valid held high: second request accepted the cycle after done (+17).
        issue(0, 2'd1, 5'h1F, 1'b0, 1'b1, -1, acc_a);
        issue(0, 2'd2, 5'h01, 1'b0, 1'b0, acc_a + 17, acc);
        drain();

        // Reset in cycle 8 of a sequence abandons it; a fresh sequence then loads.
        issue(0, 2'd3, 5'h0A, 1'b0, 1'b0, -1, acc);
        while (cyc < acc + 8) @(negedge clk);
        rst = 1'b1;
        wq0.delete(); dq0.delete();
        @(negedge clk);
        chk_reset0("midreset");
        rst = 1'b0;
        issue(0, 2'd3, 5'h15, 1'b1, 1'b0, -1, acc);
        drain();

        // GAP=1 instance: writes every other cycle.
        issue(1, 2'd1, 5'h13, 1'b1, 1'b0, -1, acc);
        drain();
        issue(1, 2'd3, 5'h07, 1'b0, 1'b0, -1, acc);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
